// File: rtl/sync_fifo_pkg.sv
// Shared sizing and pointer-increment helpers for the synchronous FIFO.
// The increment handles any depth, including non-power-of-two, by wrapping the index explicitly.
package sync_fifo_pkg;

  function automatic int ptr_bits(input int depth);
    return $clog2(depth);
  endfunction

  // Pointer is {wrap, index}; index wraps at depth-1 and toggles the wrap bit.
  function automatic logic [31:0] ptr_next(input logic [31:0] ptr, input int depth,
                                           input int pbits);
    logic [31:0] idx_mask;
    logic [31:0] idx;
    logic [31:0] wrap;
    idx_mask = (32'd1 << pbits) - 32'd1;
    idx      = ptr & idx_mask;
    wrap     = (ptr >> pbits) & 32'd1;
    if (idx == 32'(depth - 1)) begin
      idx  = '0;
      wrap = wrap ^ 32'd1;
    end else begin
      idx = idx + 32'd1;
    end
    return (wrap << pbits) | idx;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// One {wrap, index} FIFO pointer register with synchronous active-low reset.
// Instantiated once for the write side and once for the read side.
module fifo_wrap_ptr
  import sync_fifo_pkg::*;
#(
  parameter int  DEPTH = 7,
  localparam int PW    = ptr_bits(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= PW'(ptr_next(32'(ptr), DEPTH, PW - 1));
    end
  end

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO, arbitrary depth, registered read data, FULL/EMPTY from wrap-bit pointers.
// Optional overflow/underflow pulse outputs when SYNC_FIFO_ERR_FLAGS_EN is defined.
module synchronous_fifo
  import sync_fifo_pkg::*;
#(
  parameter int  DEPTH      = 7,
  parameter int  DATA_WIDTH = 6,
  localparam int PTR_BITS   = ptr_bits(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  FULL,
  output logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [PTR_BITS:0]     wr_ptr,
  output logic [PTR_BITS:0]     rd_ptr
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic [PTR_BITS-1:0]   wr_idx;
  logic [PTR_BITS-1:0]   rd_idx;
  logic                  wr_acc;
  logic                  rd_acc;

  assign wr_idx = wr_ptr[PTR_BITS-1:0];
  assign rd_idx = rd_ptr[PTR_BITS-1:0];

  assign EMPTY  = (wr_ptr == rd_ptr);
  assign FULL   = (wr_idx == rd_idx) && (wr_ptr[PTR_BITS] != rd_ptr[PTR_BITS]);

  // Flags gate acceptance, so simultaneous requests resolve to read-only when full
  // and write-only when empty.
  assign wr_acc = wr_en && !FULL;
  assign rd_acc = rd_en && !EMPTY;

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rd_acc),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wr_idx] <= data_in;
    end
  end

  // p1: registered read data, held when no read is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
    end else if (rd_acc) begin
      rd_data_p1 <= mem[rd_idx];
    end
  end

  assign data_out = rd_data_p1;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && FULL;
      underflow <= rd_en && EMPTY;
    end
  end
`endif

endmodule

// File: tb/tb_synchronous_fifo.sv
// Scoreboard bench for synchronous_fifo: directed vectors on a DEPTH=7 instance,
// plus a wrap sweep running DEPTH=7 and DEPTH=8 instances side by side.
module tb_synchronous_fifo;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;

  logic       wr_en7 = 1'b0, rd_en7 = 1'b0;
  logic [5:0] din7   = '0;
  logic       FULL7, EMPTY7;
  logic [5:0] data_out7;
  logic [3:0] wr_ptr7, rd_ptr7;

  logic       wr_en8 = 1'b0, rd_en8 = 1'b0;
  logic [5:0] din8   = '0;
  logic       FULL8, EMPTY8;
  logic [5:0] data_out8;
  logic [3:0] wr_ptr8, rd_ptr8;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf7, udf7, ovf8, udf8;
`endif

  int checks = 0;
  int errors = 0;
  logic [5:0] sb [$];

  always #5 clk = ~clk;

  synchronous_fifo #(.DEPTH(7), .DATA_WIDTH(6)) dut7 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en7), .rd_en(rd_en7),
    .FULL(FULL7), .EMPTY(EMPTY7), .data_in(din7), .data_out(data_out7),
    .wr_ptr(wr_ptr7), .rd_ptr(rd_ptr7)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(ovf7), .underflow(udf7)
`endif
  );

  synchronous_fifo #(.DEPTH(8), .DATA_WIDTH(6)) dut8 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en8), .rd_en(rd_en8),
    .FULL(FULL8), .EMPTY(EMPTY8), .data_in(din8), .data_out(data_out8),
    .wr_ptr(wr_ptr8), .rd_ptr(rd_ptr8)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(ovf8), .underflow(udf8)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_ptr(input int k, input int depth);
    return 4'((((k / depth) % 2) << 3) | (k % depth));
  endfunction

  // One clock edge on the DEPTH=7 instance; inputs return to idle afterwards.
  task automatic step7(input logic w, input logic r, input logic [5:0] d);
    wr_en7 = w;
    rd_en7 = r;
    din7   = d;
    @(posedge clk);
    @(negedge clk);
    wr_en7 = 1'b0;
    rd_en7 = 1'b0;
  endtask

  // Monitor: every observed rd_ptr advance is a delivered word, compared against the queue head.
  logic [3:0] prev_rd7 = '0;
  logic       rst_s;
  always @(posedge clk) begin
    rst_s = rst_n;
    #1;
    if (rst_s && rd_ptr7 !== prev_rd7) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: data_out %0h with empty scoreboard at %0t", data_out7, $time);
      end else begin
        check("rd_data7", 32'(data_out7), 32'(sb.pop_front()));
      end
    end
    prev_rd7 = rd_ptr7;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fill [7];
    logic [5:0] drop [4];
    logic [5:0] d;
    fill = '{6'b101010, 6'b010101, 6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000};
    drop = '{6'b100000, 6'b110011, 6'b000111, 6'b111111};

    // Reset
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_empty", 32'(EMPTY7), 32'd1);
    check("rst_full", 32'(FULL7), 32'd0);
    check("rst_wr_ptr", 32'(wr_ptr7), 32'd0);
    check("rst_rd_ptr", 32'(rd_ptr7), 32'd0);
    check("rst_data_out", 32'(data_out7), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read while empty is ignored
    step7(1'b0, 1'b1, 6'd0);
    check("empty_rd_empty", 32'(EMPTY7), 32'd1);
    check("empty_rd_ptr", 32'(rd_ptr7), 32'd0);
    check("empty_rd_data", 32'(data_out7), 32'd0);

    // Fill to DEPTH
    for (int i = 0; i < 7; i++) begin
      step7(1'b1, 1'b0, fill[i]);
      if (i == 0) check("first_wr_not_empty", 32'(EMPTY7), 32'd0);
      if (i == 5) check("six_not_full", 32'(FULL7), 32'd0);
    end
    check("fill_full", 32'(FULL7), 32'd1);
    check("fill_wr_ptr", 32'(wr_ptr7), 32'b1000);
    check("fill_rd_ptr", 32'(rd_ptr7), 32'd0);

    // Writes while FULL are dropped
    for (int i = 0; i < 4; i++) step7(1'b1, 1'b0, drop[i]);
    check("drop_wr_ptr", 32'(wr_ptr7), 32'b1000);
    check("drop_full", 32'(FULL7), 32'd1);

    // Simultaneous read+write while FULL: read only
    sb.push_back(6'b101010);
    step7(1'b1, 1'b1, 6'b100000);
    check("fullrw_full", 32'(FULL7), 32'd0);
    check("fullrw_wr_ptr", 32'(wr_ptr7), 32'b1000);
    check("fullrw_rd_ptr", 32'(rd_ptr7), 32'b0001);

    // Simultaneous read+write with neither flag: occupancy stays 6
    sb.push_back(6'b010101);
    step7(1'b1, 1'b1, 6'b100001);
    sb.push_back(6'b000001);
    step7(1'b1, 1'b1, 6'b100010);
    sb.push_back(6'b000010);
    step7(1'b1, 1'b1, 6'b100100);
    check("rw_wr_ptr", 32'(wr_ptr7), 32'b1011);
    check("rw_rd_ptr", 32'(rd_ptr7), 32'b0100);
    check("rw_full", 32'(FULL7), 32'd0);
    check("rw_empty", 32'(EMPTY7), 32'd0);

    step7(1'b1, 1'b0, 6'b111000);
    check("refill_full", 32'(FULL7), 32'd1);
    check("refill_wr_ptr", 32'(wr_ptr7), 32'b1100);

    // Drain in FIFO order
    fill = '{6'b000100, 6'b001000, 6'b010000, 6'b100001, 6'b100010, 6'b100100, 6'b111000};
    for (int i = 0; i < 7; i++) begin
      sb.push_back(fill[i]);
      step7(1'b0, 1'b1, 6'd0);
    end
    check("drain_empty", 32'(EMPTY7), 32'd1);
    check("drain_rd_ptr", 32'(rd_ptr7), 32'b1100);
    check("drain_data", 32'(data_out7), 32'b111000);

    step7(1'b0, 1'b1, 6'd0);
    step7(1'b0, 1'b1, 6'd0);
    check("over_rd_data_hold", 32'(data_out7), 32'b111000);
    check("over_rd_ptr", 32'(rd_ptr7), 32'b1100);

    // Simultaneous read+write while EMPTY: write only, no read-through
    step7(1'b1, 1'b1, 6'b011011);
    check("emptyrw_empty", 32'(EMPTY7), 32'd0);
    check("emptyrw_rd_ptr", 32'(rd_ptr7), 32'b1100);
    check("emptyrw_wr_ptr", 32'(wr_ptr7), 32'b1101);
    check("emptyrw_data", 32'(data_out7), 32'b111000);
    sb.push_back(6'b011011);
    step7(1'b0, 1'b1, 6'd0);
    check("emptyrw_drained", 32'(EMPTY7), 32'd1);

    // Reset mid-operation discards contents
    step7(1'b1, 1'b0, 6'b010110);
    step7(1'b1, 1'b0, 6'b101001);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_empty", 32'(EMPTY7), 32'd1);
    check("midrst_wr_ptr", 32'(wr_ptr7), 32'd0);
    check("midrst_rd_ptr", 32'(rd_ptr7), 32'd0);
    check("midrst_data", 32'(data_out7), 32'd0);
    step7(1'b0, 1'b1, 6'd0);
    check("midrst_rd_ignored", 32'(rd_ptr7), 32'd0);

    // Wrap sweep on both depths
    for (int i = 0; i < 24; i++) begin
      d = 6'(i * 5 + 3);
      wr_en7 = 1'b1; wr_en8 = 1'b1; din7 = d; din8 = d;
      @(posedge clk);
      @(negedge clk);
      wr_en7 = 1'b0; wr_en8 = 1'b0;
      check("wrap_wr_ptr7", 32'(wr_ptr7), 32'(exp_ptr(i + 1, 7)));
      check("wrap_wr_ptr8", 32'(wr_ptr8), 32'(exp_ptr(i + 1, 8)));
      check("wrap_wr_idx7_range", 32'(wr_ptr7[2:0] < 3'd7), 32'd1);
      sb.push_back(d);
      rd_en7 = 1'b1; rd_en8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rd_en7 = 1'b0; rd_en8 = 1'b0;
      check("wrap_rd_ptr7", 32'(rd_ptr7), 32'(exp_ptr(i + 1, 7)));
      check("wrap_rd_ptr8", 32'(rd_ptr8), 32'(exp_ptr(i + 1, 8)));
      check("wrap_data8", 32'(data_out8), 32'(d));
      check("wrap_empty8", 32'(EMPTY8), 32'd1);
    end

    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
